// File: rtl/nts_engine_arbiter_pkg.sv
// Shared types and widths for the NTS engine arbiter.
// FSM state encoding and the widths of the statistics counters and the grant watchdog.
package nts_engine_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int PACKET_COUNT_W  = 32;
    localparam int ERROR_COUNT_W   = 16;
    localparam int TIMEOUT_COUNT_W = 16;
    localparam int WATCHDOG_W      = 8;

endpackage

// File: rtl/nts_engine_arbiter_rr_select.sv
// Combinational round-robin picker.
// Returns the first set bit of idle_mask_i at or after last_grant_i + 1, wrapping
// modulo ENGINES, as a one-hot vector, plus a flag saying whether any bit was set.
module nts_rr_select #(
    parameter int ENGINES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [ENGINES-1:0] idle_mask_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [ENGINES-1:0] choice_o,
    output logic               found_o
);

    logic [IDX_W:0] idx;

    // Walk the engines in priority order starting just after the last grant.
    always_comb begin
        choice_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int off = 1; off <= ENGINES; off++) begin
            idx = {1'b0, last_grant_i} + (IDX_W+1)'(off);
            if (idx >= (IDX_W+1)'(ENGINES)) begin
                idx = idx - (IDX_W+1)'(ENGINES);
            end
            if (!found_o && idle_mask_i[idx[IDX_W-1:0]]) begin
                choice_o[idx[IDX_W-1:0]] = 1'b1;
                found_o                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nts_engine_arbiter.sv
// NTS engine arbiter: shares one dispatcher RX FIFO among ENGINES engines.
// An idle engine is chosen round-robin and owns the dispatcher for a whole packet;
// handshakes are routed only to it until its discard pulse (or busy drop) ends it.
// Optional feature macro: NTS_ENGINE_ARBITER_TIMEOUT_EN adds a grant watchdog that
// revokes a grant the engine never acknowledged with busy.
// Handshake: the dispatcher offers a packet with packet_available; the arbiter
// offers it to one engine, which pulls words with a one-cycle rd_en per word while
// fifo_empty is low, and finishes with a one-cycle read_discard pulse.
module nts_engine_arbiter
    import nts_engine_arbiter_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_areset,
    output logic                o_busy,
    input  logic                i_dispatch_packet_available,
    output logic                o_dispatch_packet_read_discard,
    input  logic [7:0]          i_dispatch_data_valid,
    input  logic                i_dispatch_fifo_empty,
    output logic                o_dispatch_fifo_rd_en,
    input  logic [63:0]         i_dispatch_fifo_rd_data,
    input  logic [ENGINES-1:0]  i_engine_busy,
    output logic [ENGINES-1:0]  o_engine_packet_available,
    input  logic [ENGINES-1:0]  i_engine_packet_read_discard,
    output logic [7:0]          o_engine_data_valid,
    output logic [ENGINES-1:0]  o_engine_fifo_empty,
    input  logic [ENGINES-1:0]  i_engine_fifo_rd_en,
    output logic [63:0]         o_engine_fifo_rd_data,
    output logic [ENGINES-1:0]  o_grant,
    output logic [31:0]         o_packet_count,
    output logic [15:0]         o_error_count,
    output logic [15:0]         o_timeout_count,
    output logic [1:0]          o_dbg_state
);

    localparam int LG_W = (ENGINES > 1) ? $clog2(ENGINES) : 1;

    state_t                    state_q, state_d;
    logic [ENGINES-1:0]        grant_q, grant_d;
    logic [LG_W-1:0]           last_grant_q, last_grant_d;
    logic                      discard_q, discard_d;
    logic [PACKET_COUNT_W-1:0] packet_count_q, packet_count_d;
    logic [ERROR_COUNT_W-1:0]  error_count_q, error_count_d;

    logic [ENGINES-1:0]        rr_choice;
    logic                      rr_found;
    logic                      granted_busy;
    logic                      granted_discard;
    logic                      timeout_hit;

    function automatic logic [LG_W-1:0] oh_to_idx(input logic [ENGINES-1:0] oh);
        logic [LG_W-1:0] r;
        r = '0;
        for (int i = 0; i < ENGINES; i++) begin
            if (oh[i]) r = LG_W'(i);
        end
        return r;
    endfunction

    nts_rr_select #(
        .ENGINES (ENGINES),
        .IDX_W   (LG_W)
    ) u_rr_select (
        .idle_mask_i  (~i_engine_busy),
        .last_grant_i (last_grant_q),
        .choice_o     (rr_choice),
        .found_o      (rr_found)
    );

    // Only the granted engine's busy and discard matter; others are ignored.
    assign granted_busy    = |(i_engine_busy & grant_q);
    assign granted_discard = |(i_engine_packet_read_discard & grant_q);

`ifdef NTS_ENGINE_ARBITER_TIMEOUT_EN
    logic [WATCHDOG_W-1:0]      wd_q, wd_d;
    logic [TIMEOUT_COUNT_W-1:0] timeout_count_q, timeout_count_d;

    // Watchdog counts cycles spent in GRANT and restarts whenever GRANT is left.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_GRANT) wd_d = wd_q + 1'b1;
        timeout_count_d = timeout_count_q;
        if (timeout_hit && (timeout_count_q != {TIMEOUT_COUNT_W{1'b1}})) begin
            timeout_count_d = timeout_count_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_GRANT) && !granted_busy &&
                         (wd_q == WATCHDOG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog and timeout statistics registers.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            wd_q            <= '0;
            timeout_count_q <= '0;
        end else begin
            wd_q            <= wd_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign o_timeout_count = timeout_count_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
    assign o_timeout_count       = '0;
`endif

    // FSM state register; reset mid-packet drops the grant without any discard.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dispatch_packet_available && rr_found) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (granted_busy)     state_d = ST_ACTIVE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (granted_discard || !granted_busy) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Grant, round-robin pointer, discard pulse and statistics next values.
    always_comb begin
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        discard_d      = 1'b0;
        packet_count_d = packet_count_q;
        error_count_d  = error_count_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dispatch_packet_available && rr_found) grant_d = rr_choice;
            end
            ST_GRANT: begin
                if (!granted_busy && timeout_hit) begin
                    grant_d      = '0;
                    last_grant_d = oh_to_idx(grant_q);
                end
            end
            ST_ACTIVE: begin
                // A discard in the same cycle as the busy drop is a normal completion.
                if (granted_discard) begin
                    discard_d = 1'b1;
                end else if (!granted_busy) begin
                    discard_d = 1'b1;
                    if (error_count_q != {ERROR_COUNT_W{1'b1}}) begin
                        error_count_d = error_count_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                grant_d        = '0;
                last_grant_d   = oh_to_idx(grant_q);
                packet_count_d = packet_count_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; last_grant starts at the top so engine 0 goes first.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            grant_q        <= '0;
            last_grant_q   <= LG_W'(ENGINES - 1);
            discard_q      <= 1'b0;
            packet_count_q <= '0;
            error_count_q  <= '0;
        end else begin
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            discard_q      <= discard_d;
            packet_count_q <= packet_count_d;
            error_count_q  <= error_count_d;
        end
    end

    // FSM outputs: routing of the dispatcher handshake to the granted engine.
    always_comb begin
        o_busy                    = (&i_engine_busy) || (state_q != ST_IDLE);
        o_engine_packet_available = '0;
        o_dispatch_fifo_rd_en     = 1'b0;
        if ((state_q == ST_GRANT) || (state_q == ST_ACTIVE)) begin
            o_engine_packet_available = grant_q & {ENGINES{i_dispatch_packet_available}};
            o_dispatch_fifo_rd_en     = |(i_engine_fifo_rd_en & grant_q);
        end
        o_engine_fifo_empty = ~grant_q | {ENGINES{i_dispatch_fifo_empty}};
    end

    assign o_dispatch_packet_read_discard = discard_q;
    assign o_engine_data_valid            = i_dispatch_data_valid;
    assign o_engine_fifo_rd_data          = i_dispatch_fifo_rd_data;
    assign o_grant                        = grant_q;
    assign o_packet_count                 = packet_count_q;
    assign o_error_count                  = error_count_q;
    assign o_dbg_state                    = state_q;

endmodule
